fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the instruction memory.
- Owns the program counter and drives the memory word address.
- Captures the combinational read data into a registered IF output (instruction, PC, valid) for decode.
- Handles stall, redirect/flush from branch and jump resolution, halt on EBREAK, and address faults.

---
 rtl/fetch_unit.sv | 113 +++++++++++
 tb/tb_fetch_unit.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and registers
// the fetched word for decode, with stall, redirect/flush, EBREAK halt and fault stop.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 32,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_valid,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fault_pc
);

  localparam logic [32:0] LIMIT  = 33'(IMEM_DEPTH * 4);
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {RUN, HALT, FAULT} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_p0, pc_nxt;
  logic [31:0] instr_p1, instr_nxt;
  logic [31:0] pc_p1, pc_p1_nxt;
  logic        vld_p1, vld_nxt;
  logic [31:0] fault_pc_q, fault_pc_nxt;
  logic [32:0] pc_inc;

  function automatic logic bad_target(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ({1'b0, a} >= LIMIT);
  endfunction

  function automatic logic past_end(input logic [32:0] a);
    return a >= LIMIT;
  endfunction

  assign pc_inc = {1'b0, pc_p0} + 33'd4;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      pc_p0      <= RESET_PC;
      instr_p1   <= NOP_INSTR;
      pc_p1      <= 32'h0;
      vld_p1     <= 1'b0;
      fault_pc_q <= 32'h0;
    end else begin
      state      <= state_nxt;
      pc_p0      <= pc_nxt;
      instr_p1   <= instr_nxt;
      pc_p1      <= pc_p1_nxt;
      vld_p1     <= vld_nxt;
      fault_pc_q <= fault_pc_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc_p0;
    instr_nxt    = instr_p1;
    pc_p1_nxt    = pc_p1;
    vld_nxt      = vld_p1;
    fault_pc_nxt = fault_pc_q;
    case (state)
      RUN: begin
        // Redirect is judged on its target alone; the word currently on the bus is discarded.
        if (redirect_valid) begin
          instr_nxt = NOP_INSTR;
          vld_nxt   = 1'b0;
          if (bad_target(redirect_target)) begin
            state_nxt    = FAULT;
            fault_pc_nxt = redirect_target;
          end else begin
            pc_nxt = redirect_target;
          end
        end else if (!stall) begin
          instr_nxt = imem_rdata;
          pc_p1_nxt = pc_p0;
          vld_nxt   = 1'b1;
          if (imem_rdata == EBREAK) begin
            state_nxt = HALT;
          end else if (past_end(pc_inc)) begin
            state_nxt    = FAULT;
            fault_pc_nxt = pc_inc[31:0];
          end else begin
            pc_nxt = pc_inc[31:0];
          end
        end
      end
      HALT:    vld_nxt = 1'b0;
      FAULT:   vld_nxt = 1'b0;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    imem_addr = pc_p0;
    if_instr  = instr_p1;
    if_pc     = pc_p1;
    if_valid  = vld_p1;
    fault_pc  = fault_pc_q;
    halted    = (state == HALT);
    fault     = (state == FAULT);
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: hand-computed per-edge vectors pushed to a scoreboard queue,
// each popped and compared against the registered outputs one edge later.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] EBK = 32'h0010_0073;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        rv;
    logic [31:0] tgt;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] ifpc;
    logic        v;
    logic        h;
    logic        f;
    logic [31:0] fpc;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic [31:0] imem_addr, imem_rdata, if_instr, if_pc, fault_pc;
  logic        if_valid, halted, fault;
  logic [31:0] mem [32];

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];
  vec_t sb[$];

  assign imem_rdata = mem[imem_addr[6:2]];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid),
    .halted(halted), .fault(fault), .fault_pc(fault_pc)
  );

  function automatic logic [31:0] w(input int i);
    return 32'hA000_0000 + 32'(i);
  endfunction

  task automatic add(input logic r, input logic s, input logic rv, input logic [31:0] t,
                     input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] ifpc,
                     input logic v, input logic h, input logic f, input logic [31:0] fpc);
    vec_t x;
    x.rst = r; x.stall = s; x.rv = rv; x.tgt = t;
    x.pc = pc; x.instr = ins; x.ifpc = ifpc; x.v = v; x.h = h; x.f = f; x.fpc = fpc;
    vecs.push_back(x);
  endtask

  task automatic chk(input int step, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL step %0d %s: got %h expected %h", step, name, act, exp);
    end
  endtask

  task automatic run_vecs();
    vec_t e;
    foreach (vecs[i]) begin
      reset = vecs[i].rst;
      stall = vecs[i].stall;
      redirect_valid = vecs[i].rv;
      redirect_target = vecs[i].tgt;
      sb.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk(i, "imem_addr", imem_addr, e.pc);
      chk(i, "if_instr", if_instr, e.instr);
      chk(i, "if_pc", if_pc, e.ifpc);
      chk(i, "if_valid", 32'(if_valid), 32'(e.v));
      chk(i, "halted", 32'(halted), 32'(e.h));
      chk(i, "fault", 32'(fault), 32'(e.f));
      chk(i, "fault_pc", fault_pc, e.fpc);
      chk(i, "halt_and_fault", 32'(halted & fault), 32'h0);
    end
    vecs.delete();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = w(i);

    // reset, free run, stall at pc=8, redirect over stall, redirect faults
    //  rst st rv tgt         pc     instr   ifpc  v  h  f  fpc
    add(1, 0, 0, 32'h0,  32'h00, NOP,  32'h00, 0, 0, 0, 32'h0);
    add(0, 0, 0, 32'h0,  32'h04, w(0), 32'h00, 1, 0, 0, 32'h0);
    add(0, 0, 0, 32'h0,  32'h08, w(1), 32'h04, 1, 0, 0, 32'h0);
    add(0, 1, 0, 32'h0,  32'h08, w(1), 32'h04, 1, 0, 0, 32'h0);
    add(0, 1, 0, 32'h0,  32'h08, w(1), 32'h04, 1, 0, 0, 32'h0);
    add(0, 1, 0, 32'h0,  32'h08, w(1), 32'h04, 1, 0, 0, 32'h0);
    add(0, 0, 0, 32'h0,  32'h0C, w(2), 32'h08, 1, 0, 0, 32'h0);
    add(0, 1, 1, 32'h20, 32'h20, NOP,  32'h08, 0, 0, 0, 32'h0);
    add(0, 0, 0, 32'h0,  32'h24, w(8), 32'h20, 1, 0, 0, 32'h0);
    add(0, 0, 1, 32'h22, 32'h24, NOP,  32'h20, 0, 0, 1, 32'h22);
    add(0, 0, 1, 32'h10, 32'h24, NOP,  32'h20, 0, 0, 1, 32'h22);
    add(0, 0, 0, 32'h0,  32'h24, NOP,  32'h20, 0, 0, 1, 32'h22);
    add(1, 0, 0, 32'h0,  32'h00, NOP,  32'h00, 0, 0, 0, 32'h0);
    add(0, 0, 0, 32'h0,  32'h04, w(0), 32'h00, 1, 0, 0, 32'h0);
    add(0, 0, 1, 32'h80, 32'h04, NOP,  32'h00, 0, 0, 1, 32'h80);
    add(1, 1, 1, 32'h0,  32'h00, NOP,  32'h00, 0, 0, 0, 32'h0);
    run_vecs();

    // EBREAK at 0x10: stalled, then flushed by redirect, then accepted
    mem[4] = EBK;
    add(1, 0, 0, 32'h0,  32'h00, NOP,  32'h00, 0, 0, 0, 32'h0);
    add(0, 0, 0, 32'h0,  32'h04, w(0), 32'h00, 1, 0, 0, 32'h0);
    add(0, 0, 0, 32'h0,  32'h08, w(1), 32'h04, 1, 0, 0, 32'h0);
    add(0, 0, 0, 32'h0,  32'h0C, w(2), 32'h08, 1, 0, 0, 32'h0);
    add(0, 0, 0, 32'h0,  32'h10, w(3), 32'h0C, 1, 0, 0, 32'h0);
    add(0, 1, 0, 32'h0,  32'h10, w(3), 32'h0C, 1, 0, 0, 32'h0);
    add(0, 0, 1, 32'h10, 32'h10, NOP,  32'h0C, 0, 0, 0, 32'h0);
    add(0, 0, 0, 32'h0,  32'h10, EBK,  32'h10, 1, 1, 0, 32'h0);
    add(0, 0, 0, 32'h0,  32'h10, EBK,  32'h10, 0, 1, 0, 32'h0);
    add(0, 1, 1, 32'h20, 32'h10, EBK,  32'h10, 0, 1, 0, 32'h0);
    add(1, 0, 0, 32'h0,  32'h00, NOP,  32'h00, 0, 0, 0, 32'h0);
    // run off the end of memory, then reset mid-run
    add(0, 0, 1, 32'h70, 32'h70, NOP,   32'h00, 0, 0, 0, 32'h0);
    add(0, 0, 0, 32'h0,  32'h74, w(28), 32'h70, 1, 0, 0, 32'h0);
    add(0, 0, 0, 32'h0,  32'h78, w(29), 32'h74, 1, 0, 0, 32'h0);
    add(0, 0, 0, 32'h0,  32'h7C, w(30), 32'h78, 1, 0, 0, 32'h0);
    add(0, 0, 0, 32'h0,  32'h7C, w(31), 32'h7C, 1, 0, 1, 32'h80);
    add(0, 0, 0, 32'h0,  32'h7C, w(31), 32'h7C, 0, 0, 1, 32'h80);
    add(1, 0, 0, 32'h0,  32'h00, NOP,   32'h00, 0, 0, 0, 32'h0);
    add(0, 0, 0, 32'h0,  32'h04, w(0),  32'h00, 1, 0, 0, 32'h0);
    add(0, 0, 0, 32'h0,  32'h08, w(1),  32'h04, 1, 0, 0, 32'h0);
    add(1, 0, 0, 32'h0,  32'h00, NOP,   32'h00, 0, 0, 0, 32'h0);
    run_vecs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
